// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Architectural register file with two combinational read ports, one
//   writeback port and a per-register pending (scoreboard) bit that marks
//   registers whose producer has issued but not yet written back.
//
//   Register 0 and addresses at or beyond NREG are hardwired: they read 0,
//   never report busy, and ignore writes and issues.
//
//   Optional feature macro: REGFILE_BYPASS_EN
//     defined   -> a same-cycle writeback is forwarded to the read ports
//                  (data and busy), so a consumer sees the value immediately.
//     undefined -> reads reflect stored contents only; a written value
//                  becomes visible the cycle after the writeback edge.
module regfile_scoreboard #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rd1_data,
  output logic [XLEN-1:0] rd2_data,
  input  logic            we,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            rs1_busy,
  output logic            rs2_busy
);

  // Width needed to index the NREG storage entries.
  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

  // Stored state: data per register and one pending bit per register.
  // Entry 0 exists only to keep indexing uniform; it is never written.
  logic [XLEN-1:0] regs_q    [NREG];
  logic [XLEN-1:0] regs_d    [NREG];
  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  // An address names a real, writable register: nonzero and below NREG.
  function automatic logic addr_legal(input logic [AW-1:0] a);
    return (a != '0) && (int'(a) < NREG);
  endfunction

  // Storage index of an address; only meaningful when addr_legal(a).
  function automatic logic [IW-1:0] addr_idx(input logic [AW-1:0] a);
    return a[IW-1:0];
  endfunction

  logic wr_legal;
  logic iss_legal;

  // Qualify the writeback and issue requests against the hardwired addresses.
  always_comb begin
    wr_legal  = we && addr_legal(wr_addr);
    iss_legal = issue_valid && addr_legal(issue_rd);
  end

  // Next-state data: a legal writeback replaces exactly one register.
  always_comb begin
    // NOTE: every always_comb output gets a full default first so that no
    // path leaves it unassigned; that is what keeps latches from appearing.
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_legal) begin
      regs_d[addr_idx(wr_addr)] = wr_data;
    end
  end

  // Next-state scoreboard: writeback clears, issue sets. The issue is applied
  // last so a same-edge issue to the written register keeps it pending
  // (the newly issued producer owns the register).
  always_comb begin
    pending_d = pending_q;
    if (wr_legal) begin
      pending_d[addr_idx(wr_addr)] = 1'b0;
    end
    if (iss_legal) begin
      pending_d[addr_idx(issue_rd)] = 1'b1;
    end
  end

  // State update with synchronous reset; reset wins over writeback and issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the storage array is reset entry by entry because the register
      // file must read 0 after reset; this makes it a flop array, not a RAM.
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      pending_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pending_q <= pending_d;
    end
  end

  // Stored view of each read port: hardwired addresses read 0 and not busy.
  logic            rs1_legal;
  logic            rs2_legal;
  logic [XLEN-1:0] rs1_stored;
  logic [XLEN-1:0] rs2_stored;
  logic            rs1_pend;
  logic            rs2_pend;

  // Look up stored data and pending bit for both read addresses.
  always_comb begin
    rs1_legal  = addr_legal(rs1_addr);
    rs2_legal  = addr_legal(rs2_addr);
    rs1_stored = '0;
    rs2_stored = '0;
    rs1_pend   = 1'b0;
    rs2_pend   = 1'b0;
    if (rs1_legal) begin
      rs1_stored = regs_q[addr_idx(rs1_addr)];
      rs1_pend   = pending_q[addr_idx(rs1_addr)];
    end
    if (rs2_legal) begin
      rs2_stored = regs_q[addr_idx(rs2_addr)];
      rs2_pend   = pending_q[addr_idx(rs2_addr)];
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic rs1_hit;
  logic rs2_hit;
  logic rs1_reissue;
  logic rs2_reissue;

  // Forward a same-cycle writeback to matching read ports. Busy drops with
  // the forwarded value unless a new producer issues to that register in the
  // same cycle, in which case busy keeps following the stored pending bit.
  always_comb begin
    rs1_hit     = wr_legal && (wr_addr == rs1_addr);
    rs2_hit     = wr_legal && (wr_addr == rs2_addr);
    rs1_reissue = iss_legal && (issue_rd == rs1_addr);
    rs2_reissue = iss_legal && (issue_rd == rs2_addr);

    rd1_data = rs1_hit ? wr_data : rs1_stored;
    rd2_data = rs2_hit ? wr_data : rs2_stored;
    rs1_busy = (rs1_hit && !rs1_reissue) ? 1'b0 : rs1_pend;
    rs2_busy = (rs2_hit && !rs2_reissue) ? 1'b0 : rs2_pend;
  end
`else
  // Without forwarding the ports show stored contents and stored busy only.
  always_comb begin
    rd1_data = rs1_stored;
    rd2_data = rs2_stored;
    rs1_busy = rs1_pend;
    rs2_busy = rs2_pend;
  end
`endif

endmodule
